// File: rtl/ram_io_pkg.sv
// rtl/ram_io_pkg.sv - access-size encodings, FSM states and MMIO constants for ram_io
package ram_io_pkg;

  // Access size field shared by write_type and read_type[1:0]
  localparam logic [1:0] SIZE_NONE = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  localparam logic [1:0] WT_NONE = SIZE_NONE;
  localparam logic [2:0] RT_NONE = 3'b000;

  // read_type bit that selects sign extension of sub-word loads
  localparam int RT_SIGN_BIT = 2;

  // Byte address of the memory-mapped LED register
  localparam logic [31:0] LED_ADDRESS = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ_WAIT,
    ST_WRITE_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ram_io_if.sv
// rtl/ram_io_if.sv - word-wide memory bus between ram_io and the backing RAM
interface ram_io_if #(
  parameter int ADDRESS_BITW = 32
);

  logic                    mem_enable;
  logic [ADDRESS_BITW-1:0] mem_address;
  logic [3:0]              mem_write_enable;
  logic [31:0]             mem_data_in;
  logic [31:0]             mem_data_out;
  logic                    mem_data_out_ready;
  logic                    mem_busy;

  // ram_io side: issues requests, consumes read data and busy
  modport master (
    output mem_enable,
    output mem_address,
    output mem_write_enable,
    output mem_data_in,
    input  mem_data_out,
    input  mem_data_out_ready,
    input  mem_busy
  );

  // RAM side
  modport slave (
    input  mem_enable,
    input  mem_address,
    input  mem_write_enable,
    input  mem_data_in,
    output mem_data_out,
    output mem_data_out_ready,
    output mem_busy
  );

endinterface

// File: rtl/ram_io_lanes.sv
// rtl/ram_io_lanes.sv - byte-lane extraction, sign extension and store mask/replication
module ram_io_lanes
  import ram_io_pkg::*;
(
  input  logic [2:0]  read_type,
  input  logic [1:0]  rd_offset,
  input  logic [31:0] rd_word,
  output logic [31:0] rd_data,
  input  logic [1:0]  write_type,
  input  logic [1:0]  wr_offset,
  input  logic [31:0] wr_data,
  output logic [3:0]  wr_mask,
  output logic [31:0] wr_lanes
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        sign_en;

  // Pick the addressed byte/half out of the memory word and extend it
  always_comb begin
    rd_byte = 8'h00;
    rd_half = rd_offset[1] ? rd_word[31:16] : rd_word[15:0];
    sign_en = read_type[RT_SIGN_BIT];
    rd_data = 32'h0;
    case (rd_offset)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    case (read_type[1:0])
      SIZE_BYTE: rd_data = {{24{sign_en & rd_byte[7]}}, rd_byte};
      SIZE_HALF: rd_data = {{16{sign_en & rd_half[15]}}, rd_half};
      SIZE_WORD: rd_data = rd_word;
      default:   rd_data = 32'h0;
    endcase
  end

  // Build the byte-lane write mask and replicate store data across lanes
  always_comb begin
    wr_mask  = 4'b0000;
    wr_lanes = 32'h0;
    case (write_type)
      SIZE_BYTE: begin
        wr_mask  = 4'b0001 << wr_offset;
        wr_lanes = {4{wr_data[7:0]}};
      end
      SIZE_HALF: begin
        wr_mask  = wr_offset[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wr_data[15:0]}};
      end
      SIZE_WORD: begin
        wr_mask  = 4'b1111;
        wr_lanes = wr_data;
      end
      default: begin
        wr_mask  = 4'b0000;
        wr_lanes = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/ram_io.sv
// rtl/ram_io.sv - core load/store adapter onto a word-wide RAM bus; optional LED MMIO via RAM_IO_MMIO_LED_EN
module ram_io
  import ram_io_pkg::*;
#(
  parameter int ADDRESS_BITW = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [1:0]              write_type,
  input  logic [2:0]              read_type,
  input  logic [ADDRESS_BITW-1:0] address,
  input  logic [31:0]             data_in,
  output logic [31:0]             data_out,
  output logic                    data_out_ready,
  output logic                    busy,
  output logic [3:0]              led,
  ram_io_if.master                mem
);

  state_t state;
  state_t state_next;

  // Shadow of the last accepted request; a held, unchanged request is not reissued
  logic                    sh_valid;
  logic [ADDRESS_BITW-1:0] sh_address;
  logic [2:0]              sh_read_type;
  logic [1:0]              sh_write_type;
  logic [31:0]             sh_data;

  logic        req_changed;
  logic        new_req;
  logic        is_led;
  logic        start_read;
  logic        start_write;
  logic [31:0] rd_data;
  logic [3:0]  wr_mask;
  logic [31:0] wr_lanes;

`ifdef RAM_IO_MMIO_LED_EN
  localparam logic [ADDRESS_BITW-1:0] LED_ADDR = ADDRESS_BITW'(LED_ADDRESS);
  assign is_led = (address == LED_ADDR);
`else
  assign is_led = 1'b0;
`endif

  // Read lanes come from the captured request; write lanes from the live one being accepted
  ram_io_lanes u_lanes (
    .read_type (sh_read_type),
    .rd_offset (sh_address[1:0]),
    .rd_word   (mem.mem_data_out),
    .rd_data   (rd_data),
    .write_type(write_type),
    .wr_offset (address[1:0]),
    .wr_data   (data_in),
    .wr_mask   (wr_mask),
    .wr_lanes  (wr_lanes)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request acceptance, next state and combinational handshake outputs
  always_comb begin
    req_changed    = !sh_valid || (address != sh_address) || (read_type != sh_read_type) ||
                     (write_type != sh_write_type) || (data_in != sh_data);
    new_req        = enable && ((state == ST_IDLE) || (state == ST_DONE)) && req_changed;
    busy           = new_req || (state == ST_READ_WAIT) || (state == ST_WRITE_WAIT);
    data_out_ready = (state == ST_DONE) && sh_valid && (sh_read_type != RT_NONE) && !new_req;
    start_read     = new_req && !is_led && (read_type != RT_NONE);
    start_write    = new_req && !is_led && (read_type == RT_NONE) && (write_type != WT_NONE);
    state_next     = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_read) begin
          state_next = ST_READ_WAIT;
        end else if (start_write) begin
          state_next = ST_WRITE_WAIT;
        end else if (new_req) begin
          state_next = ST_DONE;
        end else if (!enable) begin
          state_next = ST_IDLE;
        end
      end
      ST_READ_WAIT: begin
        if (mem.mem_data_out_ready) begin
          state_next = ST_DONE;
        end
      end
      ST_WRITE_WAIT: begin
        if (!mem.mem_busy) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture accepted requests; drop the shadow once the core releases enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_valid      <= 1'b0;
      sh_address    <= '0;
      sh_read_type  <= RT_NONE;
      sh_write_type <= WT_NONE;
      sh_data       <= 32'h0;
    end else if (new_req) begin
      sh_valid      <= 1'b1;
      sh_address    <= address;
      sh_read_type  <= read_type;
      sh_write_type <= write_type;
      sh_data       <= data_in;
    end else if ((state == ST_DONE) && !enable) begin
      sh_valid <= 1'b0;
    end
  end

  // Registered memory bus: raised the cycle after acceptance, dropped on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem.mem_enable       <= 1'b0;
      mem.mem_address      <= '0;
      mem.mem_write_enable <= 4'b0000;
      mem.mem_data_in      <= 32'h0;
    end else if (start_read) begin
      mem.mem_enable       <= 1'b1;
      mem.mem_address      <= {address[ADDRESS_BITW-1:2], 2'b00};
      mem.mem_write_enable <= 4'b0000;
    end else if (start_write) begin
      mem.mem_enable       <= 1'b1;
      mem.mem_address      <= {address[ADDRESS_BITW-1:2], 2'b00};
      mem.mem_write_enable <= wr_mask;
      mem.mem_data_in      <= wr_lanes;
    end else if (state_next == ST_DONE) begin
      mem.mem_enable       <= 1'b0;
      mem.mem_write_enable <= 4'b0000;
    end
  end

  // Load result register: holds until the next read completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= 32'h0;
    end else if ((state == ST_READ_WAIT) && mem.mem_data_out_ready) begin
      data_out <= rd_data;
`ifdef RAM_IO_MMIO_LED_EN
    end else if (new_req && is_led && (read_type != RT_NONE)) begin
      data_out <= {28'h0, led};
`endif
    end
  end

`ifdef RAM_IO_MMIO_LED_EN
  // LED register, written by any store to the LED address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 4'b1111;
    end else if (new_req && is_led && (read_type == RT_NONE) && (write_type != WT_NONE)) begin
      led <= data_in[3:0];
    end
  end
`else
  assign led = 4'b1111;
`endif

endmodule

// File: tb/tb_ram_io.sv
// tb/tb_ram_io.sv - directed self-checking bench for ram_io
module tb_ram_io;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  write_type;
  logic [2:0]  read_type;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;
  logic [3:0]  led;

  int checks = 0;
  int errors = 0;

  ram_io_if #(.ADDRESS_BITW(32)) mem ();

  ram_io #(.ADDRESS_BITW(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .write_type    (write_type),
    .read_type     (read_type),
    .address       (address),
    .data_in       (data_in),
    .data_out      (data_out),
    .data_out_ready(data_out_ready),
    .busy          (busy),
    .led           (led),
    .mem           (mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a load, memory answers in the first READ_WAIT cycle; returns in the DONE cycle
  task automatic load(input logic [31:0] a, input logic [2:0] rt, input logic [31:0] word);
    enable = 1'b1; read_type = rt; write_type = 2'b00; address = a; data_in = 32'h0;
    tick();
    mem.mem_data_out = word;
    mem.mem_data_out_ready = 1'b1;
    tick();
    mem.mem_data_out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; write_type = 2'b00; read_type = 3'b000;
    address = 32'h0; data_in = 32'h0;
    mem.mem_data_out = 32'h0; mem.mem_data_out_ready = 1'b0; mem.mem_busy = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_enable", mem.mem_enable, 0);
    chk("rst_mem_we", mem.mem_write_enable, 0);
    chk("rst_mem_address", mem.mem_address, 0);
    chk("rst_mem_data_in", mem.mem_data_in, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_led", led, 4'b1111);
    chk("rst_busy", busy, 0);
    chk("rst_ready", data_out_ready, 0);
    tick(); rst_n = 1'b1;
    tick();

    // LW 0x100, memory answers three cycles after the request
    enable = 1'b1; read_type = 3'b011; address = 32'h100;
    @(negedge clk);
    chk("lw_busy_req_cycle", busy, 1);
    chk("lw_mem_en_req_cycle", mem.mem_enable, 0);
    tick();
    @(negedge clk);
    chk("lw_mem_en_n1", mem.mem_enable, 1);
    chk("lw_mem_addr", mem.mem_address, 32'h100);
    chk("lw_mem_we", mem.mem_write_enable, 0);
    chk("lw_ready_wait", data_out_ready, 0);
    tick();
    tick();
    mem.mem_data_out = 32'h8899AABB; mem.mem_data_out_ready = 1'b1;
    @(negedge clk);
    chk("lw_ready_at_mem_ready", data_out_ready, 0);
    chk("lw_busy_at_mem_ready", busy, 1);
    tick(); mem.mem_data_out_ready = 1'b0; mem.mem_data_out = 32'h0;
    @(negedge clk);
    chk("lw_ready", data_out_ready, 1);
    chk("lw_data", data_out, 32'h8899AABB);
    chk("lw_busy_done", busy, 0);
    chk("lw_mem_en_done", mem.mem_enable, 0);

    // Sub-word loads with and without sign extension
    tick();
    load(32'h103, 3'b101, 32'h8000_0000);
    @(negedge clk);
    chk("lb_103_sext", data_out, 32'hFFFF_FF80);
    chk("lb_103_ready", data_out_ready, 1);
    tick();
    load(32'h103, 3'b001, 32'h8000_0000);
    @(negedge clk);
    chk("lbu_103", data_out, 32'h0000_0080);
    tick();
    load(32'h102, 3'b110, 32'h8001_0000);
    @(negedge clk);
    chk("lh_102_sext", data_out, 32'hFFFF_8001);
    tick();
    load(32'h101, 3'b001, 32'h1234_F00D);
    @(negedge clk);
    chk("lbu_101", data_out, 32'h0000_00F0);
    tick();
    load(32'h101, 3'b110, 32'h1234_F00D);
    @(negedge clk);
    chk("lh_101_low_half", data_out, 32'hFFFF_F00D);
    tick();

    // SB 0x201 with memory busy for two cycles
    read_type = 3'b000; write_type = 2'b01; address = 32'h201; data_in = 32'hAB;
    mem.mem_busy = 1'b1;
    @(negedge clk);
    chk("sb_busy_req_cycle", busy, 1);
    tick();
    @(negedge clk);
    chk("sb_mem_en", mem.mem_enable, 1);
    chk("sb_mem_we", mem.mem_write_enable, 4'b0010);
    chk("sb_mem_data_lane1", mem.mem_data_in[15:8], 8'hAB);
    chk("sb_mem_data", mem.mem_data_in, 32'hABAB_ABAB);
    chk("sb_mem_addr", mem.mem_address, 32'h200);
    tick(); mem.mem_busy = 1'b0;
    @(negedge clk);
    chk("sb_busy_wait", busy, 1);
    tick();
    @(negedge clk);
    chk("sb_busy_done", busy, 0);
    chk("sb_mem_en_done", mem.mem_enable, 0);
    chk("sb_mem_we_done", mem.mem_write_enable, 0);
    chk("sb_ready_write", data_out_ready, 0);
    tick();

    // SH upper half and SW
    write_type = 2'b10; address = 32'h202; data_in = 32'h1234;
    tick();
    @(negedge clk);
    chk("sh_mem_we", mem.mem_write_enable, 4'b1100);
    chk("sh_mem_data", mem.mem_data_in, 32'h1234_1234);
    tick();
    write_type = 2'b11; address = 32'h300; data_in = 32'hDEAD_BEEF;
    tick();
    @(negedge clk);
    chk("sw_mem_we", mem.mem_write_enable, 4'b1111);
    chk("sw_mem_data", mem.mem_data_in, 32'hDEAD_BEEF);
    chk("sw_mem_addr", mem.mem_address, 32'h300);
    tick();

    // LW 0x40 then hold: no second access while the request is unchanged
    load(32'h40, 3'b011, 32'hCAFE_F00D);
    @(negedge clk);
    chk("lw40_data", data_out, 32'hCAFE_F00D);
    repeat (5) begin
      tick();
      @(negedge clk);
      chk("lw40_hold_mem_en", mem.mem_enable, 0);
      chk("lw40_hold_ready", data_out_ready, 1);
    end
    tick(); address = 32'h44;
    @(negedge clk);
    chk("lw44_ready_drops", data_out_ready, 0);
    chk("lw44_busy", busy, 1);
    tick(); address = 32'h48;
    @(negedge clk);
    chk("lw44_addr_ignores_change", mem.mem_address, 32'h44);
    mem.mem_data_out = 32'h1111_2222; mem.mem_data_out_ready = 1'b1;
    tick(); mem.mem_data_out_ready = 1'b0;
    @(negedge clk);
    chk("lw44_data", data_out, 32'h1111_2222);
    chk("lw48_pending_ready", data_out_ready, 0);
    chk("lw48_pending_busy", busy, 1);
    tick();
    @(negedge clk);
    chk("lw48_mem_addr", mem.mem_address, 32'h48);
    mem.mem_data_out = 32'h3333_4444; mem.mem_data_out_ready = 1'b1;
    tick(); mem.mem_data_out_ready = 1'b0;
    @(negedge clk);
    chk("lw48_data", data_out, 32'h3333_4444);
    chk("lw48_ready", data_out_ready, 1);

    // Reset while a read is in flight
    tick(); address = 32'h80;
    tick();
    @(negedge clk);
    chk("lw80_mem_en", mem.mem_enable, 1);
    tick(); rst_n = 1'b0; enable = 1'b0;
    #1;
    chk("rstfly_mem_en", mem.mem_enable, 0);
    @(negedge clk);
    chk("rstfly_busy", busy, 0);
    chk("rstfly_ready", data_out_ready, 0);
    chk("rstfly_led", led, 4'b1111);
    chk("rstfly_data_out", data_out, 0);
    chk("rstfly_mem_addr", mem.mem_address, 0);
    tick(); rst_n = 1'b1;
    tick();

    // Request with no read and no write completes without a memory access
    enable = 1'b1; read_type = 3'b000; write_type = 2'b00; address = 32'h10;
    @(negedge clk);
    chk("nop_busy_req", busy, 1);
    tick();
    @(negedge clk);
    chk("nop_busy_done", busy, 0);
    chk("nop_mem_en", mem.mem_enable, 0);
    chk("nop_ready", data_out_ready, 0);
    tick(); enable = 1'b0;
    tick();

    // Store to 0xFFFF_FFFF
    enable = 1'b1; write_type = 2'b01; address = 32'hFFFF_FFFF; data_in = 32'h5;
`ifdef RAM_IO_MMIO_LED_EN
    @(negedge clk);
    chk("led_mem_en_req", mem.mem_enable, 0);
    tick();
    @(negedge clk);
    chk("led_value", led, 4'b0101);
    chk("led_mem_en", mem.mem_enable, 0);
    chk("led_busy_done", busy, 0);
    tick();
    write_type = 2'b00; read_type = 3'b001;
    tick();
    @(negedge clk);
    chk("led_read", data_out, 32'h5);
    chk("led_read_ready", data_out_ready, 1);
    chk("led_read_mem_en", mem.mem_enable, 0);
`else
    tick();
    @(negedge clk);
    chk("ffff_mem_en", mem.mem_enable, 1);
    chk("ffff_mem_addr", mem.mem_address, 32'hFFFF_FFFC);
    chk("ffff_mem_we", mem.mem_write_enable, 4'b1000);
    chk("ffff_led", led, 4'b1111);
`endif
    tick(); enable = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
